// File: rtl/vga_tile_controller.sv
// VGA raster timing with tiled glyph-memory addressing and colour output.
// Define VGA_TILE_BLINK_EN to add the blink_en input and 32-frame blink.
module vga_tile_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 14,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 14'h2200,
    parameter int TW_LOG2 = 3,
    parameter int TH_LOG2 = 4
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic [7:0]        glyph_sel,
    input  logic [2:0]        fg_color,
    input  logic [2:0]        bg_color,
`ifdef VGA_TILE_BLINK_EN
    input  logic              blink_en,
`endif
    output logic [ADDR_W-1:0] addr,
    input  logic              data,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic [2:0]        rgbOut,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int G_SHIFT = TW_LOG2 + TH_LOG2;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [7:0]    glyph_r;
    logic [2:0]    fg_r;
    logic [2:0]    bg_r;

    // raw/dly bit order: {frame marker, de, vsync, hsync}
    logic [3:0] raw;
    logic [3:0] dly;
    logic       blink_on;

    // Raster counters; glyph and colours are latched on the edge that
    // enters pixel (0,0) so the new values govern the whole next frame.
    always_ff @(posedge vga_clk) begin
        if (!rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            glyph_r <= '0;
            fg_r    <= '0;
            bg_r    <= '0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + VW'(1);
                end
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
            if (h_cnt == H_LAST && v_cnt == V_LAST) begin
                glyph_r <= glyph_sel;
                fg_r    <= fg_color;
                bg_r    <= bg_color;
            end
        end
    end

    assign raw[0] = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign raw[1] = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    assign raw[2] = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign raw[3] = (h_cnt == '0) && (v_cnt == '0);

    assign addr = BASE_ADDR
                + (ADDR_W'(glyph_r) << G_SHIFT)
                + ADDR_W'({v_cnt[TH_LOG2-1:0], h_cnt[TW_LOG2-1:0]});

    generate
        if (RD_LAT == 0) begin : g_pass
            assign dly = raw;
        end else begin : g_pipe
            logic [3:0] pipe [RD_LAT];

            // Delay timing markers to line up with glyph-memory read data
            always_ff @(posedge vga_clk) begin
                if (!rst) begin
                    for (int i = 0; i < RD_LAT; i++) begin
                        pipe[i] <= 4'b0000;
                    end
                end else begin
                    pipe[0] <= raw;
                    for (int i = 1; i < RD_LAT; i++) begin
                        pipe[i] <= pipe[i-1];
                    end
                end
            end

            assign dly = pipe[RD_LAT-1];
        end
    endgenerate

    assign vga_hsync   = dly[0] ? SYNC_POL : ~SYNC_POL;
    assign vga_vsync   = dly[1] ? SYNC_POL : ~SYNC_POL;
    assign frame_start = dly[3];

`ifdef VGA_TILE_BLINK_EN
    logic [4:0] frame_cnt;
    logic [4:0] frame_idx;

    // Count frame_start pulses
    always_ff @(posedge vga_clk) begin
        if (!rst) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 5'd1;
        end
    end

    // The pulse cycle already shows the new frame's first pixel
    assign frame_idx = frame_cnt - {4'b0000, ~frame_start};
    assign blink_on  = blink_en && (frame_idx >= 5'd16);
`else
    assign blink_on = 1'b0;
`endif

    // Colour select from the glyph bit, blanked outside the active area
    always_comb begin
        rgbOut = 3'b000;
        if (dly[2]) begin
            rgbOut = (data && !blink_on) ? fg_r : bg_r;
        end
    end

endmodule

// File: doc/vga_tile_controller.md
VGA_TILE_CONTROLLER -- requirements
Module: vga_tile_controller

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48: horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
REQ-004 SHALL have parameter SYNC_POL, default 0: asserted sync level (0 = active-low).
REQ-005 SHALL have parameter RD_LAT, default 2, legal range 0..4: glyph-memory read latency in vga_clk cycles.
REQ-006 SHALL have parameters ADDR_W 14, BASE_ADDR 14'h2200, TW_LOG2 3, TH_LOG2 4: address width, glyph-table base, and tile width/height as log2.
REQ-007 SHALL have port vga_clk, input, 1 bit: the single pixel clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port glyph_sel, input, 8 bits: glyph index.
REQ-010 SHALL have ports fg_color and bg_color, input, 3 bits each: foreground and background colours.
REQ-011 SHALL have port addr, output, ADDR_W bits: glyph-memory read address.
REQ-012 SHALL have port data, input, 1 bit: pixel bit returned RD_LAT cycles after addr.
REQ-013 SHALL have ports vga_hsync and vga_vsync, output, 1 bit each; rgbOut, output, 3 bits.
REQ-014 SHALL have port frame_start, output, 1 bit: one-cycle pulse.

Function
REQ-015 SHALL count h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters), wrapping to 0.
REQ-016 SHALL increment v_cnt only on the cycle h_cnt wraps; v_cnt wraps 0 after V_TOTAL-1.
REQ-017 SHALL assert raw hsync while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vsync likewise on v_cnt.
REQ-018 SHALL assert raw de while h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-019 SHALL drive addr combinationally = BASE_ADDR + (glyph_r << (TW_LOG2+TH_LOG2)) + {v_cnt[TH_LOG2-1:0], h_cnt[TW_LOG2-1:0]}, truncated modulo 2^ADDR_W.
REQ-020 SHALL capture glyph_sel, fg_color and bg_color into glyph_r, fg_r and bg_r only on the cycle h_cnt=0, v_cnt=0; mid-frame changes take effect the next frame.
REQ-021 SHALL delay raw hsync, vsync, de and frame marker through RD_LAT register stages; RD_LAT=0 means pass-through.
REQ-022 SHALL apply SYNC_POL to delayed syncs: output = SYNC_POL when asserted, ~SYNC_POL otherwise.
REQ-023 SHALL drive rgbOut = delayed de ? (data ? fg_r : bg_r) : 3'b000, combinationally from data.
REQ-024 SHALL pulse frame_start for one cycle, RD_LAT cycles after h_cnt=0, v_cnt=0.

Reset
REQ-025 SHALL, while rst=0 at a clock edge, clear h_cnt, v_cnt, glyph_r, fg_r, bg_r and all delay stages.
REQ-026 SHALL reset delay stages to deasserted sync level, de=0 and frame marker 0, so outputs read syncs=~SYNC_POL, rgbOut=000, frame_start=0.
REQ-027 SHALL, on reset mid-line, restart at h_cnt=0, v_cnt=0 on the first edge with rst=1; there is no partial-frame recovery.

Configuration
REQ-028 SHALL, with macro VGA_TILE_BLINK_EN defined, add input blink_en (1 bit) and a 5-bit frame counter incremented on each frame_start and reset to 0.
REQ-029 SHALL, with VGA_TILE_BLINK_EN defined and blink_en=1 while counter[4]=1, force active-area rgbOut to bg_r regardless of data.
REQ-030 SHALL, without VGA_TILE_BLINK_EN, have no blink_en port, no frame counter and no blink behaviour.

Verification
REQ-031 SHALL cover reset: defaults, rst=0 for 3 cycles -> hsync=vsync=1, rgbOut=000, frame_start=0; after release, first frame_start 2 cycles after release.
REQ-032 SHALL cover line timing: defaults -> vga_hsync low for exactly 96 cycles per 800-cycle line, falling 658 cycles after the line's h_cnt=0; frame_start period 420000 cycles.
REQ-033 SHALL cover addressing: glyph_sel=0 from reset, h_cnt=13, v_cnt=5 -> addr=14'h222D; glyph_sel=3 applied mid-frame -> unchanged until next frame, then addr at h=0, v=0 = 14'h2380.
REQ-034 SHALL cover colour: fg=101, bg=010, data=1 in active area -> rgbOut=101; data=0 -> 010; h_cnt=700 (blanking) -> 000 regardless of data.
REQ-035 SHALL cover mid-line reset: rst=0 at h_cnt=300, v_cnt=200 -> counters restart at 0 and next hsync falls 658 cycles after release.
REQ-036 SHALL cover blink: with VGA_TILE_BLINK_EN, blink_en=1, data=1 -> frames 0-15 show fg, frames 16-31 show bg, repeating.
